seq_gen_101_110_tx: RTL
=======================

Name: seq_gen_101_110_tx

Overview:
Serial pattern transmitter that emits repeated 101 or 110 bit patterns, one bit per clock. It is the stimulus and traffic source for the team's 101/110 Moore sequence detectors. A request is accepted on a start/ready handshake and supplies a pattern select, a repetition count and an inter-pattern idle gap. The block then streams the patterns on `out`, qualified by `out_valid`, and signals completion with a one-cycle `done` pulse.

Parameters:
CNT_W, 4, width of repetition count `reps` (max 2^CNT_W-1 patterns per request)
GAP_W, 3, width of idle-gap length `gap` (0..2^GAP_W-1 idle cycles between patterns)

Ports:
clk    input   1      clock, all logic on rising edge
rstn   input   1      reset, synchronous, active-low
start  input   1      request strobe; accepted only when ready=1
sel    input   1      pattern select: 0 -> 101, 1 -> 110 (MSB first)
reps   input   CNT_W  number of patterns to send
gap    input   GAP_W  idle cycles inserted between consecutive patterns
abort  input   1      terminate the current request; return to idle without done
ready  output  1      block idle, can accept start
busy   output  1      request in progress (state != IDLE)
out    output  1      serial data bit
out_valid output 1    out carries a pattern bit this cycle
last   output  1      high on the final bit of the final pattern
done   output  1      one-cycle completion pulse

Behaviour:
- Reset: clk and rstn as decided above (synchronous, active-low). While rstn=0 at a clock edge: state=IDLE, repetition/gap counters and latched sel/reps/gap cleared. Resulting outputs: ready=1, busy=0, out=0, out_valid=0, last=0, done=0.
- Reset mid-request aborts it: IDLE after the edge, no done pulse.
- Moore machine. Every output decodes only from registered state, counters and latched sel. No input-to-output combinational path.
- States: IDLE, B0, B1, B2 (pattern bits 1..3), GAP, DONE.
- IDLE:
  - ready=1.
  - On start=1 and abort=0: latch sel, reps, gap; load rem=reps.
  - If reps=0, go to DONE; otherwise go to B0.
- B0/B1/B2: one cycle each, out_valid=1.
  - sel=0: out = 1, 0, 1.
  - sel=1: out = 1, 1, 0.
- B2 exit: rem decrements by 1.
  - If the new rem=0, go to DONE; last=1 during this B2.
  - Else if gap=0, go to B0 (patterns back to back).
  - Else go to GAP with gcnt=gap.
- GAP: out=0, out_valid=0. Lasts exactly `gap` cycles (gcnt decrements each cycle), then B0.
- DONE: one cycle, done=1, out=0, out_valid=0, busy=1. Then IDLE.
- Latency:
  - start sampled at edge k -> first bit B0 visible in the cycle after edge k.
  - For reps=N>=1 and gap=G: 3N + G(N-1) bit/gap cycles, then 1 DONE cycle; ready returns the cycle after that.
- Outside B-states, out is always 0.
- start while busy (including the DONE cycle) is ignored. Latched parameters stay unchanged, and input changes during a request have no effect.
- abort=1 in any non-IDLE state: IDLE at the next edge, no done, last not asserted.
  - abort=1 in IDLE blocks acceptance of a simultaneous start.
  - Priority: rstn > abort > start.
- Counters do not wrap: reps=2^CNT_W-1 sends exactly that many patterns, and rem never underflows.

Test Plan:
- Reset: hold rstn=0 for 2 cycles with start=1 -> ready=1, busy=0, out=0, out_valid=0, done=0; no request accepted.
- sel=0, reps=1, gap=0 -> out_valid high 3 cycles, out=1,0,1, last on the 3rd bit; done=1 the next cycle; ready=1 one cycle later.
- sel=1, reps=3, gap=2 -> out/out_valid sequence 1,1,0,(0,0 invalid),1,1,0,(0,0 invalid),1,1,0 over 13 cycles; last only on cycle 13; done on cycle 14.
- reps=0 with start -> no out_valid; done one cycle after acceptance; ready the cycle after that.
- sel=0, reps=4, gap=1:
  - assert abort during the 2nd pattern's B1 -> IDLE next cycle, out_valid=0, no done, no last.
  - start pulsed during the transfer is ignored: the pattern count stays as originally requested when the test is rerun without abort.
- sel=1, reps=15, gap=7, with rstn=0 driven mid-GAP -> all outputs at reset values after that edge. A fresh start with reps=2, gap=0 then emits 110110 and a single done.

Source files
------------

// File: rtl/seq_gen_101_110_tx.sv
// Serial 101/110 pattern transmitter: streams repeated 3-bit patterns with
// optional idle gaps, qualified by out_valid, ending with a one-cycle done.
module seq_gen_101_110_tx #(
   parameter int CNT_W = 4,
   parameter int GAP_W = 3
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic             sel,
   input  logic [CNT_W-1:0] reps,
   input  logic [GAP_W-1:0] gap,
   input  logic             abort,
   output logic             ready,
   output logic             busy,
   output logic             out,
   output logic             out_valid,
   output logic             last,
   output logic             done
);

   typedef enum logic [2:0] {IDLE, B0, B1, B2, GAP, DONE} state_t;

   state_t           state, state_nxt;
   logic             sel_q, sel_nxt;
   logic [CNT_W-1:0] rem, rem_nxt;
   logic [GAP_W-1:0] gap_q, gap_nxt, gcnt, gcnt_nxt;

   always_comb begin
      state_nxt = state;
      sel_nxt   = sel_q;
      rem_nxt   = rem;
      gap_nxt   = gap_q;
      gcnt_nxt  = gcnt;
      if (state != IDLE && abort) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start && !abort) begin
                  sel_nxt   = sel;
                  rem_nxt   = reps;
                  gap_nxt   = gap;
                  state_nxt = (reps == '0) ? DONE : B0;
               end
            end
            B0: state_nxt = B1;
            B1: state_nxt = B2;
            B2: begin
               // rem counts patterns still owed, including the one ending now
               if (rem <= CNT_W'(1)) begin
                  rem_nxt   = '0;
                  state_nxt = DONE;
               end else begin
                  rem_nxt = rem - CNT_W'(1);
                  if (gap_q == '0) begin
                     state_nxt = B0;
                  end else begin
                     gcnt_nxt  = gap_q;
                     state_nxt = GAP;
                  end
               end
            end
            GAP: begin
               gcnt_nxt = (gcnt == '0) ? '0 : gcnt - GAP_W'(1);
               if (gcnt <= GAP_W'(1)) state_nxt = B0;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Outputs are decoded from the next state so they are registered yet
   // still line up with the state they describe.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state     <= IDLE;
         sel_q     <= 1'b0;
         rem       <= '0;
         gap_q     <= '0;
         gcnt      <= '0;
         ready     <= 1'b1;
         busy      <= 1'b0;
         out       <= 1'b0;
         out_valid <= 1'b0;
         last      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         sel_q     <= sel_nxt;
         rem       <= rem_nxt;
         gap_q     <= gap_nxt;
         gcnt      <= gcnt_nxt;
         ready     <= (state_nxt == IDLE);
         busy      <= (state_nxt != IDLE);
         out_valid <= (state_nxt == B0) || (state_nxt == B1) || (state_nxt == B2);
         last      <= (state_nxt == B2) && (rem_nxt == CNT_W'(1));
         done      <= (state_nxt == DONE);
         case (state_nxt)
            B0:      out <= 1'b1;
            B1:      out <= sel_nxt;
            B2:      out <= ~sel_nxt;
            default: out <= 1'b0;
         endcase
      end
   end

endmodule
